// File: rtl/tqvp_led_pwm_pkg.sv
// Shared definitions for the multi-channel LED/PWM peripheral: register map,
// control/status bit positions and the bus write-width merge helper.
package tqvp_led_pwm_pkg;

    localparam logic [5:0] ADDR_CTRL         = 6'h00;
    localparam logic [5:0] ADDR_PRESCALE     = 6'h04;
    localparam logic [5:0] ADDR_STATUS       = 6'h08;
    localparam logic [5:0] ADDR_IRQ_EN       = 6'h0C;
    localparam logic [5:0] ADDR_DUTY_BASE    = 6'h10;
    localparam logic [5:0] ADDR_BLINK_PERIOD = 6'h30;
    localparam logic [5:0] ADDR_BLINK_MASK   = 6'h34;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_INV_BIT   = 1;
    localparam int CTRL_CH_EN_LSB = 8;

    localparam int STATUS_PERIOD_BIT = 0;
    localparam int STATUS_BLINK_BIT  = 1;

    localparam logic [1:0] WR_BYTE = 2'b00;
    localparam logic [1:0] WR_HALF = 2'b01;
    localparam logic [1:0] WR_WORD = 2'b10;
    localparam logic [1:0] WR_NONE = 2'b11;

    // Replace the low byte / half / whole word of a register image.
    function automatic logic [31:0] merge_write(input logic [31:0] old_val,
                                                input logic [31:0] wdata,
                                                input logic [1:0]  write_n);
        logic [31:0] result;
        case (write_n)
            WR_BYTE: result = {old_val[31:8], wdata[7:0]};
            WR_HALF: result = {old_val[31:16], wdata[15:0]};
            WR_WORD: result = wdata;
            default: result = old_val;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/tqvp_pwm_channel.sv
// One PWM channel: staging duty written by the bus, active duty used by the
// comparator, reloaded on period wrap (or continuously while disabled).
module tqvp_pwm_channel
    import tqvp_led_pwm_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                wrap,
    input  logic                duty_we,
    input  logic [PWM_BITS:0]   duty_wdata,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic [PWM_BITS:0]   duty_stage,
    output logic                duty_on
);

    logic [PWM_BITS:0] stage_reg;
    logic [PWM_BITS:0] active_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_reg  <= '0;
            active_reg <= '0;
        end else begin
            if (duty_we) begin
                stage_reg <= duty_wdata;
            end
            if (!en || wrap) begin
                active_reg <= stage_reg;
            end
        end
    end

    assign duty_stage = stage_reg;
    // The extra duty bit makes duty >= 2^PWM_BITS compare true for every count.
    assign duty_on    = ({1'b0, pwm_cnt} < active_reg);

endmodule

// File: rtl/tqvp_led_pwm.sv
// TinyQV user peripheral: NUM_CH shadowed PWM channels sharing a prescaled
// counter, with blink gating, output inversion and period/blink interrupts.
module tqvp_led_pwm
    import tqvp_led_pwm_pkg::*;
#(
    parameter int NUM_CH        = 8,
    parameter int PWM_BITS      = 8,
    parameter int PRESCALE_BITS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ui_in,
    output logic [7:0]  uo_out,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        user_interrupt
);

    logic [15:0]              ctrl_reg;
    logic [PRESCALE_BITS-1:0] prescale_reg;
    logic [1:0]               status_reg;
    logic [1:0]               irq_en_reg;
    logic [15:0]              blink_period_reg;
    logic [7:0]               blink_mask_reg;
    logic [PRESCALE_BITS-1:0] pre_cnt_reg;
    logic [PWM_BITS-1:0]      pwm_cnt_reg;
    logic [15:0]              blink_cnt_reg;
    logic                     blink_phase_reg;
    logic                     irq_reg;
    logic [7:0]               uo_reg;
    logic [7:0]               uo_next;

    logic                     wr;
    logic                     ctrl_we, prescale_we, status_we, irq_en_we;
    logic                     blink_period_we, blink_mask_we;
    logic [NUM_CH-1:0]        duty_we;
    logic [PRESCALE_BITS-1:0] prescale_wdata;
    logic                     en, inv;
    logic [7:0]               ch_en;
    logic                     tick, wrap, blink_toggle, prescale_shrink;
    logic [1:0]               status_set, status_clr;
    logic [NUM_CH-1:0]        duty_on;
    logic [NUM_CH-1:0]        raw;
    logic [PWM_BITS:0]        duty_stage [NUM_CH];
    logic                     unused_inputs;

    assign unused_inputs = ^{ui_in, data_read_n};

    assign wr              = (data_write_n != WR_NONE);
    assign ctrl_we         = wr && (address == ADDR_CTRL);
    assign prescale_we     = wr && (address == ADDR_PRESCALE);
    assign status_we       = wr && (address == ADDR_STATUS);
    assign irq_en_we       = wr && (address == ADDR_IRQ_EN);
    assign blink_period_we = wr && (address == ADDR_BLINK_PERIOD);
    assign blink_mask_we   = wr && (address == ADDR_BLINK_MASK);
    assign prescale_wdata  = PRESCALE_BITS'(merge_write(32'(prescale_reg), data_in, data_write_n));

    assign en    = ctrl_reg[CTRL_EN_BIT];
    assign inv   = ctrl_reg[CTRL_INV_BIT];
    assign ch_en = ctrl_reg[CTRL_CH_EN_LSB +: 8];

    always_comb begin
        tick         = en && (pre_cnt_reg == prescale_reg);
        wrap         = tick && (pwm_cnt_reg == '1);
        blink_toggle = wrap && (blink_period_reg != '0)
                       && (blink_cnt_reg == blink_period_reg - 16'd1);
        // Equal as well as smaller: pre_cnt would otherwise step past PRESCALE and run away.
        prescale_shrink = prescale_we && (prescale_wdata <= pre_cnt_reg);
        status_set = '0;
        status_set[STATUS_PERIOD_BIT] = wrap;
        status_set[STATUS_BLINK_BIT]  = blink_toggle;
        status_clr = status_we ? data_in[1:0] : 2'b00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_reg <= '0;
            pwm_cnt_reg <= '0;
        end else if (!en) begin
            pre_cnt_reg <= '0;
            pwm_cnt_reg <= '0;
        end else begin
            if (tick || prescale_shrink) begin
                pre_cnt_reg <= '0;
            end else begin
                pre_cnt_reg <= pre_cnt_reg + PRESCALE_BITS'(1);
            end
            if (tick) begin
                pwm_cnt_reg <= pwm_cnt_reg + PWM_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
        end else if (blink_period_reg == '0) begin
            blink_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
        end else if (blink_toggle) begin
            blink_cnt_reg   <= '0;
            blink_phase_reg <= ~blink_phase_reg;
        end else if (wrap) begin
            blink_cnt_reg   <= blink_cnt_reg + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_reg         <= '0;
            prescale_reg     <= '0;
            status_reg       <= '0;
            irq_en_reg       <= '0;
            blink_period_reg <= '0;
            blink_mask_reg   <= '0;
            irq_reg          <= 1'b0;
            uo_reg           <= '0;
        end else begin
            if (ctrl_we)         ctrl_reg         <= 16'(merge_write(32'(ctrl_reg), data_in, data_write_n));
            if (prescale_we)     prescale_reg     <= prescale_wdata;
            if (irq_en_we)       irq_en_reg       <= 2'(merge_write(32'(irq_en_reg), data_in, data_write_n));
            if (blink_period_we) blink_period_reg <= 16'(merge_write(32'(blink_period_reg), data_in, data_write_n));
            if (blink_mask_we)   blink_mask_reg   <= 8'(merge_write(32'(blink_mask_reg), data_in, data_write_n));
            // Set is OR-ed in after the clear so a coincident event is never lost.
            status_reg <= (status_reg & ~status_clr) | status_set;
            irq_reg    <= |(status_reg & irq_en_reg);
            uo_reg     <= uo_next;
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign duty_we[gi] = wr && (address == ADDR_DUTY_BASE + 6'(4 * gi));

        tqvp_pwm_channel #(.PWM_BITS(PWM_BITS)) u_channel (
            .clk        (clk),
            .rst_n      (rst_n),
            .en         (en),
            .wrap       (wrap),
            .duty_we    (duty_we[gi]),
            .duty_wdata ((PWM_BITS+1)'(merge_write(32'(duty_stage[gi]), data_in, data_write_n))),
            .pwm_cnt    (pwm_cnt_reg),
            .duty_stage (duty_stage[gi]),
            .duty_on    (duty_on[gi])
        );

        assign raw[gi] = en & ch_en[gi] & duty_on[gi] & ~(blink_phase_reg & blink_mask_reg[gi]);
    end

    always_comb begin
        uo_next = '0;
        uo_next[NUM_CH-1:0] = raw ^ {NUM_CH{inv}};
    end

    always_comb begin
        data_out = '0;
        case (address)
            ADDR_CTRL:         data_out = 32'(ctrl_reg);
            ADDR_PRESCALE:     data_out = 32'(prescale_reg);
            ADDR_STATUS:       data_out = 32'(status_reg);
            ADDR_IRQ_EN:       data_out = 32'(irq_en_reg);
            ADDR_BLINK_PERIOD: data_out = 32'(blink_period_reg);
            ADDR_BLINK_MASK:   data_out = 32'(blink_mask_reg);
            default:           data_out = '0;
        endcase
        for (int i = 0; i < NUM_CH; i++) begin
            if (address == ADDR_DUTY_BASE + 6'(4 * i)) begin
                data_out = 32'(duty_stage[i]);
            end
        end
    end

    assign uo_out         = uo_reg;
    assign user_interrupt = irq_reg;
    assign data_ready     = 1'b1;

endmodule
